// File: rtl/pr3_pkg.sv
// Shared types for the FFT frame scheduler: FSM encoding, channel-tag width, sample format.
// Pure declarations, no logic.
// No flow control of its own.
package pr3_pkg;

    localparam int SAMPLE_W = 14;

    // Q<SAMPLE_W>.0 time-domain sample as carried on the FFT sink stream
    typedef logic signed [SAMPLE_W-1:0] q_sample_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        STREAM = 2'd2,
        GAP    = 2'd3
    } sched_state_t;

    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// Antenna-tag FIFO between frame issue and spectrum return; overflow/underflow pulse flags.
// Latency: head is combinational from storage; push+pop on empty bypasses push_dat to pop_dat.
// Backpressure: none internally; full/empty exported, illegal push/pop dropped and flagged.
module tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty,
    output logic         overflow,
    output logic         underflow
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_en;
    logic          rd_en;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    // Push+pop together is legal at any fill level; on empty the tag passes straight through.
    assign wr_en     = push && (!full || pop) && !(empty && pop);
    assign rd_en     = pop && !empty;
    assign overflow  = push && full && !pop;
    assign underflow = pop && empty && !push;
    assign pop_dat   = empty ? push_dat : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/fft_scheduler.sv
// Issues whole frames from NSINK requesters onto one FFT stream with sop/eop and antenna tags.
// Latency: samples 1 cycle; 3 idle cycles eop->sop; FFT_SCHED_ROUND_ROBIN_EN selects RR arbitration.
// Backpressure: no new frame granted while TAGDEPTH frames are in flight (tag FIFO full).
module fft_scheduler import pr3_pkg::*; #(
    parameter  int NSINK    = 3,
    parameter  int WIDTH    = SAMPLE_W,
    parameter  int LENGTH   = 2048,
    parameter  int TAGDEPTH = 4,
    localparam int CHW      = chan_width(NSINK)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NSINK-1:0]            req,
    output logic [NSINK-1:0]            grant,
    input  logic [NSINK-1:0]            sink_valid,
    input  logic [NSINK-1:0][WIDTH-1:0] sink_data,
    output logic                        source_valid,
    output logic                        source_sop,
    output logic                        source_eop,
    output logic [WIDTH-1:0]            source_data,
    output logic [CHW-1:0]              source_chan,
    input  logic                        ret_sop,
    output logic [CHW-1:0]              ret_chan,
    output logic                        ret_chan_valid,
    output logic                        busy,
    output logic                        error
);
    localparam int CNTW = $clog2(LENGTH);

    sched_state_t   state;
    sched_state_t   state_nxt;
    logic [CNTW-1:0] cnt;
    logic [CHW-1:0] win;
    logic [CHW-1:0] arb_win;
    logic           arb_found;
    logic           start_frame;
    logic           accept;
    logic           last;
    logic           tag_push;
    logic [CHW-1:0] fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_ovf;
    logic           fifo_udf;

`ifdef FFT_SCHED_ROUND_ROBIN_EN
    logic [CHW-1:0] rr_ptr;
    logic [CHW-1:0] rr_cand;

    always_comb begin
        arb_win   = '0;
        arb_found = 1'b0;
        rr_cand   = '0;
        for (int k = 0; k < NSINK; k++) begin
            rr_cand = CHW'((int'(rr_ptr) + k) % NSINK);
            if (!arb_found && req[rr_cand]) begin
                arb_found = 1'b1;
                arb_win   = rr_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (start_frame) begin
            rr_ptr <= (arb_win == CHW'(NSINK-1)) ? '0 : arb_win + CHW'(1);
        end
    end
`else
    always_comb begin
        arb_win   = '0;
        arb_found = 1'b0;
        for (int k = NSINK-1; k >= 0; k--) begin
            if (req[k]) begin
                arb_found = 1'b1;
                arb_win   = CHW'(k);
            end
        end
    end
`endif

    assign start_frame = (state == IDLE) && (state_nxt == GRANT);
    // Only the granted requester's strobe counts, and only once the grant has settled.
    assign accept      = (state == STREAM) && sink_valid[win];
    assign last        = accept && (cnt == CNTW'(LENGTH-1));
    assign tag_push    = accept && (cnt == '0);
    assign busy        = (state != IDLE);
    assign source_chan = win;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_found && !fifo_full) state_nxt = GRANT;
            GRANT:   state_nxt = STREAM;
            STREAM:  if (last) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win          <= '0;
            grant        <= '0;
            cnt          <= '0;
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_data  <= '0;
        end else begin
            source_valid <= accept;
            source_sop   <= tag_push;
            source_eop   <= last;
            if (accept) begin
                source_data <= sink_data[win];
                cnt         <= last ? '0 : cnt + CNTW'(1);
            end
            if (start_frame) begin
                win   <= arb_win;
                grant <= NSINK'(1) << arb_win;
            end else if (last) begin
                grant <= '0;
            end
        end
    end

    tag_fifo #(
        .W     (CHW),
        .DEPTH (TAGDEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tag_push),
        .push_dat  (win),
        .pop       (ret_sop),
        .pop_dat   (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (fifo_ovf),
        .underflow (fifo_udf)
    );

    // The returned tag stays on ret_chan until the next returning frame replaces it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ret_chan       <= '0;
            ret_chan_valid <= 1'b0;
            error          <= 1'b0;
        end else begin
            if (ret_sop) begin
                if (fifo_udf) begin
                    ret_chan_valid <= 1'b0;
                end else begin
                    ret_chan       <= fifo_head;
                    ret_chan_valid <= 1'b1;
                end
            end
            if (fifo_ovf || fifo_udf) error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_scheduler.sv
// Directed bench for fft_scheduler (NSINK=3, LENGTH=8, TAGDEPTH=4); expectations follow FFT_SCHED_ROUND_ROBIN_EN.
module tb_fft_scheduler;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        req;
    logic [2:0]        grant;
    logic [2:0]        sink_valid;
    logic [2:0][13:0]  sink_data;
    logic              source_valid;
    logic              source_sop;
    logic              source_eop;
    logic [13:0]       source_data;
    logic [1:0]        source_chan;
    logic              ret_sop;
    logic [1:0]        ret_chan;
    logic              ret_chan_valid;
    logic              busy;
    logic              error;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    bit  gap_mode = 1'b0;

    int  mq_cyc[$];
    int  mq_dat[$];
    int  mq_sop[$];
    int  mq_eop[$];
    int  mq_chan[$];
    int  mq_gnt[$];
    int  g_cyc[$];
    int  g_val[$];
    int  prev_g = 0;

    int  seen[3];
    int  idx[3];
    int  sc[3];

    int  exp_c[4];
    int  exp_g[4];
    int  exp5_g;
    int  drain[4];

    always #5 clk = ~clk;

    fft_scheduler #(
        .NSINK    (3),
        .WIDTH    (14),
        .LENGTH   (8),
        .TAGDEPTH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .grant          (grant),
        .sink_valid     (sink_valid),
        .sink_data      (sink_data),
        .source_valid   (source_valid),
        .source_sop     (source_sop),
        .source_eop     (source_eop),
        .source_data    (source_data),
        .source_chan    (source_chan),
        .ret_sop        (ret_sop),
        .ret_chan       (ret_chan),
        .ret_chan_valid (ret_chan_valid),
        .busy           (busy),
        .error          (error)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled just after the active edge
    always @(posedge clk) begin
        #1;
        if (source_valid) begin
            mq_cyc.push_back(cyc);
            mq_dat.push_back(int'(source_data));
            mq_sop.push_back(int'(source_sop));
            mq_eop.push_back(int'(source_eop));
            mq_chan.push_back(int'(source_chan));
            mq_gnt.push_back(int'(grant));
        end
        if (grant != 3'b000 && prev_g == 0) begin
            g_cyc.push_back(cyc);
            g_val.push_back(int'(grant));
        end
        prev_g = int'(grant);
    end

    // Requester model: waits one cycle after grant, then streams base+1..base+8; others drive junk
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (grant[i]) begin
                if (seen[i] == 0) begin
                    seen[i] = 1;
                    sc[i]   = 0;
                    idx[i]  = 0;
                    sink_valid[i] = 1'b0;
                end else begin
                    if (sink_valid[i]) idx[i]++;
                    if (idx[i] < 8) begin
                        sink_valid[i] = gap_mode ? ((sc[i] % 4 == 0) || (sc[i] % 4 == 3)) : 1'b1;
                        sink_data[i]  = 14'(16*i + idx[i] + 1);
                    end else begin
                        sink_valid[i] = 1'b0;
                    end
                    sc[i]++;
                end
            end else begin
                seen[i] = 0;
                idx[i]  = 0;
                sink_valid[i] = 1'b1;
                sink_data[i]  = 14'h2AAA;
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        mq_cyc.delete(); mq_dat.delete(); mq_sop.delete(); mq_eop.delete();
        mq_chan.delete(); mq_gnt.delete(); g_cyc.delete(); g_val.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_mon();
    endtask

    task automatic wait_grant(input int budget, output int g);
        g = 0;
        for (int k = 0; k < budget && g == 0; k++) begin
            @(negedge clk);
            g = int'(grant);
        end
    endtask

    task automatic wait_entries(input int n, input int budget, input string tag);
        for (int k = 0; k < budget && mq_dat.size() < n; k++) @(negedge clk);
        check(tag, mq_dat.size(), n);
    endtask

    task automatic pop_check(input string tag, input int exp_chan);
        ret_sop = 1'b1;
        @(negedge clk);
        ret_sop = 1'b0;
        check({tag, "_chan"}, int'(ret_chan), exp_chan);
        check({tag, "_vld"}, int'(ret_chan_valid), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
`ifdef FFT_SCHED_ROUND_ROBIN_EN
        exp_c  = '{0, 1, 2, 0};
        exp_g  = '{1, 2, 4, 1};
        exp5_g = 2;
        drain  = '{1, 2, 0, 1};
`else
        exp_c  = '{0, 0, 0, 0};
        exp_g  = '{1, 1, 1, 1};
        exp5_g = 1;
        drain  = '{0, 0, 0, 0};
`endif
        reset = 1'b1; req = 3'b000; ret_sop = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant", int'(grant), 0);
        check("rst_src_valid", int'(source_valid), 0);
        check("rst_sop", int'(source_sop), 0);
        check("rst_eop", int'(source_eop), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_error", int'(error), 0);
        check("rst_ret_vld", int'(ret_chan_valid), 0);
        check("rst_src_chan", int'(source_chan), 0);
        reset = 1'b0;
        clear_mon();

        // Single frame, continuous samples; req dropped right after grant
        req = 3'b001;
        wait_grant(20, g);
        check("t1_grant", g, 1);
        req = 3'b000;
        wait_entries(8, 40, "t1_count");
        repeat (3) @(negedge clk);
        check("t1_total", mq_dat.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check("t1_data", mq_dat[k], k + 1);
            check("t1_sop", mq_sop[k], (k == 0) ? 1 : 0);
            check("t1_eop", mq_eop[k], (k == 7) ? 1 : 0);
            check("t1_chan", mq_chan[k], 0);
        end
        check("t1_first_latency", mq_cyc[0] - g_cyc[0], 2);
        check("t1_contiguous", mq_cyc[7] - mq_cyc[0], 7);
        check("t1_grant_before_eop", mq_gnt[6], 1);
        check("t1_grant_at_eop", mq_gnt[7], 0);
        check("t1_busy_after", int'(busy), 0);
        pop_check("t1_ret", 0);

        // All requesters held: arbitration order, spacing, then tag FIFO backpressure
        do_reset();
        req = 3'b111;
        wait_entries(32, 300, "t2_count");
        for (int f = 0; f < 4; f++) begin
            check("t2_grant", g_val[f], exp_g[f]);
            check("t2_chan", mq_chan[8*f], exp_c[f]);
            check("t2_sop", mq_sop[8*f], 1);
            check("t2_eop", mq_eop[8*f+7], 1);
            check("t2_first_data", mq_dat[8*f], 16*exp_c[f] + 1);
            if (f > 0) check("t2_spacing", mq_cyc[8*f] - mq_cyc[8*f-1], 4);
        end
        repeat (10) @(negedge clk);
        check("t4_busy_full", int'(busy), 0);
        check("t4_grant_full", int'(grant), 0);
        check("t4_frames", g_val.size(), 4);
        pop_check("t4_ret", 0);
        wait_grant(10, g);
        check("t4_fifth_grant", g, exp5_g);
        req = 3'b000;
        wait_entries(40, 60, "t4_fifth_count");
        check("t4_fifth_sop", mq_sop[32], 1);
        for (int k = 0; k < 4; k++) pop_check("t4_drain", drain[k]);

        // Return with empty FIFO: sticky error, cleared by reset
        ret_sop = 1'b1;
        @(negedge clk);
        ret_sop = 1'b0;
        check("t5_error", int'(error), 1);
        check("t5_ret_vld", int'(ret_chan_valid), 0);
        @(negedge clk);
        check("t5_error_sticky", int'(error), 1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_error_reset", int'(error), 0);
        reset = 1'b0;
        clear_mon();

        // Gappy sink_valid 1,0,0,1,...
        gap_mode = 1'b1;
        req = 3'b001;
        wait_grant(20, g);
        req = 3'b000;
        wait_entries(8, 60, "t3_count");
        repeat (6) @(negedge clk);
        check("t3_total", mq_dat.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check("t3_data", mq_dat[k], k + 1);
            check("t3_eop", mq_eop[k], (k == 7) ? 1 : 0);
            check("t3_sop", mq_sop[k], (k == 0) ? 1 : 0);
        end
        check("t3_gap_a", mq_cyc[1] - mq_cyc[0], 3);
        check("t3_gap_b", mq_cyc[2] - mq_cyc[1], 1);
        gap_mode = 1'b0;

        // Reset while sample 4 is being presented
        do_reset();
        req = 3'b001;
        wait_grant(20, g);
        req = 3'b000;
        wait_entries(4, 20, "t6_pre");
        reset = 1'b1;
        @(negedge clk);
        check("t6_grant", int'(grant), 0);
        check("t6_src_valid", int'(source_valid), 0);
        check("t6_eop", int'(source_eop), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_aborted", mq_dat.size(), 4);
        check("t6_no_eop", mq_eop[3], 0);
        reset = 1'b0;
        clear_mon();
        req = 3'b001;
        wait_grant(20, g);
        req = 3'b000;
        wait_entries(8, 40, "t6_restart");
        check("t6_sop", mq_sop[0], 1);
        check("t6_first", mq_dat[0], 1);
        check("t6_last", mq_dat[7], 8);
        check("t6_last_eop", mq_eop[7], 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fft_scheduler.md
Name: fft_scheduler

Overview:
Sequences whole time-domain frames from NSINK per-antenna requesters onto the single shared FFT sink stream, one frame at a time, and generates sop/eop framing. Each issued frame is tagged with its antenna index. The tag is replayed when that frame's spectrum re-emerges from the FFT/polar pipeline, so downstream peak/phase logic knows which antenna it is processing. It sits between the input buffering and fft_int, in the main clock domain.

Parameters:
NSINK, 3, number of requesters (antennas)
WIDTH, 14, sample width Q<WIDTH>.0
LENGTH, 2048, samples per frame (power of two, >=4)
TAGDEPTH, 4, frames allowed in flight between issue and return (power of two)

Ports:
clk  in  1  main clock
reset  in  1  synchronous reset, active-high
req  in  NSINK  requester i holds a complete frame
grant  out  NSINK  one-hot; requester i owns the FFT stream
sink_valid  in  NSINK  per-requester sample strobe
sink_data  in  NSINK x WIDTH  per-requester samples, Q<WIDTH>.0
source_valid  out  1  sample to FFT valid
source_sop  out  1  first sample of frame
source_eop  out  1  last sample of frame
source_data  out  WIDTH  sample to FFT
source_chan  out  CHW  index of frame being issued (CHW = max(1,clog2(NSINK)))
ret_sop  in  1  sop of returning (transformed) frame
ret_chan  out  CHW  tag of returning frame
ret_chan_valid  out  1  ret_chan meaningful
busy  out  1  state != IDLE
error  out  1  sticky tag FIFO overflow/underflow

Behaviour:
- Reset: all outputs 0; state IDLE; counter 0; RR pointer 0; tag FIFO empty. Reset mid-frame aborts at once. No eop is emitted. Requesters see grant drop the next cycle.
- FSM states IDLE, GRANT, STREAM, GAP.
- IDLE: if any req and tag FIFO not full, choose winner (see feature) -> GRANT. If the FIFO is full, stay in IDLE (backpressure).
- GRANT: grant[win] rises (registered). source_chan = win. -> STREAM.
- STREAM: each cycle with sink_valid[win]=1, register sink_data[win] to source_data and set source_valid=1. Latency is exactly 1 cycle. sink_valid of non-granted requesters is ignored.
- Sample counter is 0..LENGTH-1 and advances only on accepted samples. source_sop when counter=0; source_eop when counter=LENGTH-1.
- Gaps: sink_valid low gives source_valid low; counter holds; no timeout.
- Tag push: win is pushed into the tag FIFO on the sop cycle.
- Frame end: after the eop sample, grant clears the next cycle -> GAP.
- req deasserting mid-frame is ignored; the frame completes.
- GAP: one idle cycle, all grants 0 -> IDLE. Minimum spacing between frames is therefore 3 cycles (eop to next sop).
- Return path: on ret_sop, pop FIFO head into ret_chan and set ret_chan_valid=1 from the next cycle. Both hold until the next ret_sop.
- ret_sop with FIFO empty: set error, ret_chan_valid=0.
- A push while full cannot occur by construction. If it does, set error and drop the tag.
- Simultaneous push and pop are legal in any occupancy, including full (count unchanged).

Optional Feature:
FFT_SCHED_ROUND_ROBIN_EN:
- Defined: round-robin arbitration. Search starts at RR pointer = last winner+1 modulo NSINK; the pointer updates on each grant.
- Undefined: fixed priority, lowest asserted index wins; no pointer register.

Decomposition:
- Package pr3_pkg:
  - sched_state_t enum (IDLE, GRANT, STREAM, GAP)
  - chan_width function (CHW)
  - shared Q-format typedef for WIDTH samples
- Sub-module tag_fifo: CHW-wide, TAGDEPTH-deep synchronous FIFO with full/empty/overflow/underflow flags and synchronous active-high reset.

Test Plan (LENGTH=8, NSINK=3, TAGDEPTH=4):
1. req=3'b001, sink_valid[0] held high, data 1..8 -> grant=001. Source shows data 1..8 one cycle later; sop on 1, eop on 8, source_chan=0. Grant drops the cycle after eop.
2. req=3'b111 held, RR_EN defined -> frames issued in channel order 0,1,2,0. Undefined -> 0,0,0,0. In both cases, 3 cycles from eop to next sop.
3. sink_valid[0] pattern 1,0,0,1,... across 8 samples -> counter holds during gaps. Exactly 8 source_valid pulses; eop only on the 8th.
4. Issue 4 frames with no ret_sop -> the 5th req is not granted and busy=0. One ret_sop -> ret_chan=first tag, ret_chan_valid=1, 5th frame granted.
5. ret_sop with FIFO empty -> error=1 (sticky), ret_chan_valid=0. reset -> error=0.
6. reset asserted at sample 4 of a frame -> next cycle: grant=0, source_valid=0, no eop. Next frame starts with sop at sample 0.
